mux_rr_arbiter4: RTL and testbench

Round-robin arbiter that shares one 4:1 multiplexer among four requesters. Each requester raises a request line and presents one data bit. The block grants one requester at a time, drives the mux select, and registers the selected bit with a valid strobe. It sits directly in front of the existing `multiplexer4x1` datapath and is its only source of `sel`.

---
 rtl/mux_arb_pkg.sv | 36 +++
 rtl/mux_rr_arbiter4_mux.sv | 18 +
 rtl/mux_rr_arbiter4.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encodings, sizes,
// and the rotating-priority search used by both idle arbitration and release.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } search_t;

  // First set request bit at or after 'start', wrapping modulo N_REQ.
  // Scanning from the far end down lets the nearest hit overwrite later ones.
  function automatic search_t rr_search(input logic [N_REQ-1:0] req,
                                        input logic [SEL_W-1:0] start);
    search_t          res;
    logic [SEL_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter4_mux.sv
// Plain 4:1 single-bit multiplexer; the arbiter is its only source of select.
module multiplexer4x1 (
  input  logic [3:0] w,
  input  logic [1:0] s,
  output logic       f
);

  // Pure combinational select.
  always_comb begin
    case (s)
      2'd0:    f = w[0];
      2'd1:    f = w[1];
      2'd2:    f = w[2];
      default: f = w[3];
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter4.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters. A grant is
// held while its requester keeps asking, up to MAX_HOLD cycles (legal 1..15),
// then priority rotates past the owner and a new winner is picked in the same
// cycle so the mux never idles while someone is waiting.
module mux_rr_arbiter4
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     w,
  output logic [N_REQ-1:0]     gnt,
  output logic [SEL_W-1:0]     sel,
  output logic                 y,
  output logic                 valid
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             y_reg, valid_reg;
  logic [N_REQ-1:0] gnt_comb;
  logic             mux_out;
  logic [SEL_W-1:0] rel_start;
  search_t          idle_hit, rel_hit;

  // On release the search starts just past the current owner.
  assign rel_start = sel_reg + SEL_W'(1);
  assign idle_hit  = rr_search(req, ptr_reg);
  assign rel_hit   = rr_search(req, rel_start);

  multiplexer4x1 u_mux (
    .w (w),
    .s (sel_reg),
    .f (mux_out)
  );

  // State register: FSM state, priority pointer, select and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: arbitrate from idle, hold, or release and re-arbitrate.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (idle_hit.found) begin
          state_next = ST_GRANT;
          sel_next   = idle_hit.idx;
          cnt_next   = 4'd1;
        end
      end
      ST_GRANT: begin
        if (req[sel_reg] && (cnt_reg < MAX_CNT)) begin
          cnt_next = cnt_reg + 4'd1;
        end else begin
          // The expired owner becomes lowest priority; if it is the only
          // requester it still wins again with a fresh count.
          ptr_next = rel_start;
          if (rel_hit.found) begin
            sel_next = rel_hit.idx;
            cnt_next = 4'd1;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: one-hot grant of the selected requester while granting.
  always_comb begin
    gnt_comb = '0;
    if (state_reg == ST_GRANT) begin
      gnt_comb[sel_reg] = 1'b1;
    end
  end

  // Data path: register the mux output and flag it when it is a granted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= mux_out;
      valid_reg <= (state_reg == ST_GRANT) && req[sel_reg];
    end
  end

  assign gnt   = gnt_comb;
  assign sel   = sel_reg;
  assign y     = y_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_mux_rr_arbiter4.sv
// Directed bench for mux_rr_arbiter4 with MAX_HOLD = 4.
module tb_mux_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .w     (w),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, leaving inputs quiet.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    w     = 4'b0000;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    w     = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b want 0", y); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want %b", gnt, 4'b0001); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_first_sel: got %0d want 0", sel); end
    $display("test_reset done: gnt=%b sel=%0d", gnt, sel);
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    w   = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want %b", gnt, 4'b0100); end
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL single_sel: got %0d want 2", sel); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", valid); end
    tick();
    n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL single_y: got %b want 1", y); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid); end
    // Re-grants at each 4-cycle expiry must be seamless.
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++; if (gnt !== 4'b0100 || valid !== 1'b1) begin n_fail++; $display("FAIL single_hold[%0d]: got gnt=%b valid=%b want gnt=0100 valid=1", i, gnt, valid); end
    end
    $display("test_single done: gnt=%b y=%b valid=%b", gnt, y, valid);
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    int         owner;
    int         prev_owner;
    apply_reset();
    req = 4'b1111;
    w   = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      tick();
      owner   = (i / 4) % 4;
      exp_gnt = 4'b0001 << owner;
      n_checks++; if (gnt !== exp_gnt || sel !== 2'(owner)) begin n_fail++; $display("FAIL rotation[%0d]: got gnt=%b sel=%0d want gnt=%b sel=%0d", i, gnt, sel, exp_gnt, owner); end
      if (i > 0) begin
        prev_owner = ((i - 1) / 4) % 4;
        n_checks++; if (y !== w[prev_owner] || valid !== 1'b1) begin n_fail++; $display("FAIL rotation_data[%0d]: got y=%b valid=%b want y=%b valid=1", i, y, valid, w[prev_owner]); end
      end
    end
    $display("test_rotation done: final sel=%0d", sel);
  endtask

  task automatic test_early_release();
    apply_reset();
    req = 4'b0010;
    tick();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL early_first_gnt: got %b want %b", gnt, 4'b0010); end
    tick();
    req = 4'b1001;
    tick();
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL early_next_gnt: got %b want %b", gnt, 4'b1000); end
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL early_next_sel: got %0d want 3", sel); end
    $display("test_early_release done: gnt=%b", gnt);
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0010;
    w   = 4'b0010;
    tick();
    tick();
    n_checks++; if (gnt !== 4'b0010 || y !== 1'b1 || valid !== 1'b1) begin n_fail++; $display("FAIL async_pre: got gnt=%b y=%b valid=%b want gnt=0010 y=1 valid=1", gnt, y, valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000 || sel !== 2'd0 || y !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL async_clear: got gnt=%b sel=%0d y=%b valid=%b want all zero", gnt, sel, y, valid); end
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    n_checks++; if (gnt !== 4'b0001 || sel !== 2'd0) begin n_fail++; $display("FAIL async_after: got gnt=%b sel=%0d want gnt=0001 sel=0", gnt, sel); end
    $display("test_async_reset done: gnt=%b", gnt);
  endtask

  task automatic test_idle_return();
    apply_reset();
    req = 4'b0100;
    w   = 4'b0100;
    tick();
    tick();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL idle_valid_before: got %b want 1", valid); end
    req = 4'b0000;
    tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
    tick();
    n_checks++; if (valid !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_valid: got valid=%b gnt=%b want valid=0 gnt=0000", valid, gnt); end
    $display("test_idle_return done: gnt=%b valid=%b", gnt, valid);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    w     = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_async_reset();
    test_idle_return();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
